dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port 64-bit data SRAM (sram_BW64 core port) between the CPU MEM stage and an external host master (debug/DMA).
- The CPU has default priority. A starvation counter bounds host wait time: when it expires, the host is forced through and the CPU is stalled for one cycle.
- Sits between the EX/MEM pipeline register outputs and data_memory. The MEM-stage rdata returns through this block.

Parameters:
- ADDR_W, 64, address width on all ports.
- DATA_W, 64, data width on all ports.
- MAX_WAIT, 4, maximum consecutive cycles the host may be refused before a forced grant (legal range 1..15).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  main clock.
- arst_n  in  1  reset.
- cpu_en  in  1  CPU running. When 0, CPU requests are ignored and the host always wins.
- cpu_ren  in  1  MEM-stage read request (mem_read_EX_MEM).
- cpu_wen  in  1  MEM-stage write request (mem_write_EX_MEM).
- cpu_addr  in  ADDR_W  MEM-stage address.
- cpu_wdata  in  DATA_W  MEM-stage store data.
- cpu_rdata  out  DATA_W  load data, valid the cycle after the CPU read is issued.
- cpu_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle; the CPU must hold its request.
- host_req  in  1  host access request; must be held with its attributes until granted.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access issued this cycle (combinational).
- host_rvalid  out  1  host read data valid (registered pulse).
- host_rdata  out  DATA_W  host read data, qualified by host_rvalid.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wen  out  1  SRAM write enable.
- mem_ren  out  1  SRAM read enable.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, 1-cycle latency.
- conflict_cnt  out  CNT_W  saturating count of forced-grant cycles.

Behaviour:
- Reset is asynchronous and active-low. While arst_n=0: host_gnt=0, cpu_stall=0, mem_wen=0, mem_ren=0, host_rvalid=0, conflict_cnt=0, wait_cnt=0, rd_owner=NONE.
- Definitions: cpu_act = cpu_en & (cpu_ren | cpu_wen); force = host_req & (wait_cnt == MAX_WAIT).
- Grant (combinational, evaluated every cycle):
  - host_gnt = host_req & (!cpu_act | force).
  - cpu_stall = cpu_act & host_gnt.
  - The CPU is issued when cpu_act & !host_gnt.
- SRAM mux:
  - Issued master drives mem_addr/mem_wdata.
  - mem_wen/mem_ren = issued request's we/re.
  - If no master is issued: mem_wen = mem_ren = 0 and address/data = 0.
  - If cpu_ren and cpu_wen are both 1, the write takes precedence and no read is issued.
- wait_cnt (0..MAX_WAIT):
  - Cleared on host_gnt or !host_req.
  - Otherwise +1 per refused cycle.
  - Never exceeds MAX_WAIT.
- Read return, rd_owner register ∈ {NONE, CPU, HOST}:
  - Loaded each cycle with the owner of the issued read, or NONE.
  - cpu_rdata = mem_rdata when rd_owner=CPU, else 0.
  - host_rvalid = (rd_owner == HOST); host_rdata = mem_rdata when host_rvalid, else 0.
  - Read latency is exactly 1 cycle for both masters.
  - Back-to-back reads from alternating masters are legal, one per cycle.
- conflict_cnt: +1 in every cycle with cpu_stall=1; saturates at all-ones.
- Stall release: a forced grant clears wait_cnt, so the CPU is issued the following cycle. cpu_stall is never asserted on two consecutive cycles.
- Same-address, same-cycle write conflict: the forced host write is applied first and the CPU write one cycle later, so the CPU value persists.
- cpu_en falling mid-stream: takes effect the same cycle. An outstanding CPU read still returns on cpu_rdata.
- Reset mid-read: the outstanding read is dropped and no host_rvalid is produced after reset release.

Test Plan:
1. CPU idle; host read of addr 0x10 holding 0xDEADBEEF_00000001 → host_gnt same cycle, host_rvalid=1 next cycle with that data, cpu_stall=0.
2. CPU loads every cycle with host_req held → host_gnt=0 for 4 cycles, then forced on cycle 5 with cpu_stall=1 for exactly one cycle. conflict_cnt goes 0→1, wait_cnt returns to 0.
3. Alternating reads (CPU addr 0x8, host addr 0x20) on consecutive cycles → cpu_rdata and host_rdata each return their own words; host_rvalid never asserted in a CPU-return cycle.
4. Forced grant with host write 0x1 and CPU write 0x2 to addr 0x40 in the same cycle → final memory value at 0x40 is 0x2; stall lasts 1 cycle.
5. cpu_en=0 with cpu_wen=1 asserted → host granted immediately, mem_wen follows host_we only, cpu_stall=0.
6. Host read granted, then arst_n pulsed low before the next edge → no host_rvalid after release; all outputs 0; conflict_cnt=0.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Brief    : Bus bundle for the data-SRAM port arbiter: CPU MEM-stage port,
//             host (debug/DMA) port and the SRAM core port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
);
    // CPU MEM-stage side
    logic              cpu_en;
    logic              cpu_ren;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    // Host master side
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    // SRAM core port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic              mem_ren;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [CNT_W-1:0]  conflict_cnt;

    // Arbiter view
    modport slave (
        input  cpu_en, cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_wen, mem_ren, mem_wdata,
        input  mem_rdata,
        output conflict_cnt
    );

    // Environment view (pipeline, host and SRAM together)
    modport master (
        output cpu_en, cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_wen, mem_ren, mem_wdata,
        output mem_rdata,
        input  conflict_cnt
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Shares the single-port 64-bit data SRAM between the CPU MEM stage
//             (default priority) and a host master with bounded wait time.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             arst_n,
    dmem_port_arbiter_if.slave    bus
);

    localparam int                c_WAIT_W   = 4;
    localparam logic [c_WAIT_W-1:0] c_MAX_WAIT = c_WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_HOST = 2'd2
    } rd_owner_t;

    rd_owner_t             r_rd_owner;
    rd_owner_t             w_rd_owner_nxt;

    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_WAIT_W-1:0]   w_wait_cnt_nxt;
    logic [CNT_W-1:0]      r_conflict_cnt;

    logic                  w_cpu_act;
    logic                  w_force;
    logic                  w_host_gnt;
    logic                  w_cpu_stall;
    logic                  w_cpu_issue;
    logic                  w_cpu_wr;
    logic                  w_cpu_rd;

    logic [ADDR_W-1:0]     w_mem_addr;
    logic [DATA_W-1:0]     w_mem_wdata;
    logic                  w_mem_wen;
    logic                  w_mem_ren;

    // Grant decision; gated by reset so nothing reaches the SRAM while held.
    always_comb begin
        w_cpu_act   = bus.cpu_en & (bus.cpu_ren | bus.cpu_wen);
        w_force     = bus.host_req & (r_wait_cnt == c_MAX_WAIT);
        w_host_gnt  = arst_n & bus.host_req & (~w_cpu_act | w_force);
        w_cpu_stall = w_cpu_act & w_host_gnt;
        w_cpu_issue = arst_n & w_cpu_act & ~w_host_gnt;
        w_cpu_wr    = w_cpu_issue & bus.cpu_wen;
        w_cpu_rd    = w_cpu_issue & bus.cpu_ren & ~bus.cpu_wen;
    end

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_wen   = 1'b0;
        w_mem_ren   = 1'b0;
        if (w_host_gnt) begin
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
            w_mem_wen   = bus.host_we;
            w_mem_ren   = ~bus.host_we;
        end else if (w_cpu_issue) begin
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_mem_wen   = w_cpu_wr;
            w_mem_ren   = w_cpu_rd;
        end
    end

    // Refused-cycle counter; reaching MAX_WAIT forces the next host grant.
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!bus.host_req || w_host_gnt) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt < c_MAX_WAIT) begin
            w_wait_cnt_nxt = r_wait_cnt + c_WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Read-return ownership tracks which master issued last cycle's read.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rd_owner <= RD_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_owner_nxt = RD_NONE;
        if (w_host_gnt && !bus.host_we) begin
            w_rd_owner_nxt = RD_HOST;
        end else if (w_cpu_rd) begin
            w_rd_owner_nxt = RD_CPU;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_cpu_stall && (r_conflict_cnt != {CNT_W{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
        end
    end

    assign bus.host_gnt     = w_host_gnt;
    assign bus.cpu_stall    = w_cpu_stall;
    assign bus.mem_addr     = w_mem_addr;
    assign bus.mem_wdata    = w_mem_wdata;
    assign bus.mem_wen      = w_mem_wen;
    assign bus.mem_ren      = w_mem_ren;
    assign bus.cpu_rdata    = (r_rd_owner == RD_CPU)  ? bus.mem_rdata : '0;
    assign bus.host_rvalid  = (r_rd_owner == RD_HOST);
    assign bus.host_rdata   = (r_rd_owner == RD_HOST) ? bus.mem_rdata : '0;
    assign bus.conflict_cnt = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Brief    : Directed self-checking bench for dmem_port_arbiter with a
//             behavioural 1-cycle-latency SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_port_arbiter;

    localparam logic [63:0] c_W08 = 64'h0000_0008_CAFE_0008;
    localparam logic [63:0] c_W10 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] c_W20 = 64'h2020_2020_BEEF_0020;

    logic        clk;
    logic        arst_n;
    logic        preload;
    int          vectors;
    int          miscompares;
    logic [63:0] sram [0:255];

    dmem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64), .CNT_W(16)) bus ();

    dmem_port_arbiter #(
        .ADDR_W   (64),
        .DATA_W   (64),
        .MAX_WAIT (4),
        .CNT_W    (16)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: write-then-read storage, registered read data
    always @(posedge clk) begin
        if (preload) begin
            sram[1]       <= c_W08;
            sram[2]       <= c_W10;
            sram[4]       <= c_W20;
            sram[8]       <= 64'h0;
            sram[9]       <= 64'h0;
            bus.mem_rdata <= 64'h0;
        end else begin
            if (bus.mem_wen) sram[bus.mem_addr[10:3]] <= bus.mem_wdata;
            if (bus.mem_ren) bus.mem_rdata <= sram[bus.mem_addr[10:3]];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_en     = 1'b1;
        bus.cpu_ren    = 1'b0;
        bus.cpu_wen    = 1'b0;
        bus.cpu_addr   = 64'h0;
        bus.cpu_wdata  = 64'h0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = 64'h0;
        bus.host_wdata = 64'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.cpu_ren  = 1'b1;
        bus.host_req = 1'b1;
        arst_n  = 1'b0;
        preload = 1'b1;
        tick();
        tick();
        vectors++; if (bus.host_gnt !== 1'b0) begin miscompares++; $display("FAIL reset host_gnt: got %b want 0", bus.host_gnt); end
        vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL reset cpu_stall: got %b want 0", bus.cpu_stall); end
        vectors++; if ({bus.mem_wen, bus.mem_ren} !== 2'b00) begin miscompares++; $display("FAIL reset mem_wen/ren: got %b want 00", {bus.mem_wen, bus.mem_ren}); end
        vectors++; if (bus.host_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset host_rvalid: got %b want 0", bus.host_rvalid); end
        vectors++; if (bus.conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL reset conflict_cnt: got %0d want 0", bus.conflict_cnt); end
        vectors++; if (dut.r_wait_cnt !== 4'd0) begin miscompares++; $display("FAIL reset wait_cnt: got %0d want 0", dut.r_wait_cnt); end
        idle_inputs();
        arst_n  = 1'b1;
        preload = 1'b0;
        tick();
    endtask

    task automatic test_host_read_idle();
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 64'h10;
        #2;
        vectors++; if (bus.host_gnt !== 1'b1) begin miscompares++; $display("FAIL idle host_gnt: got %b want 1", bus.host_gnt); end
        vectors++; if (bus.cpu_stall !== 1'b0) begin miscompares++; $display("FAIL idle cpu_stall: got %b want 0", bus.cpu_stall); end
        vectors++; if ({bus.mem_ren, bus.mem_wen, bus.mem_addr} !== {2'b10, 64'h10}) begin miscompares++; $display("FAIL idle mem_port: got ren=%b wen=%b addr=%h want ren=1 wen=0 addr=10", bus.mem_ren, bus.mem_wen, bus.mem_addr); end
        tick();
        bus.host_req = 1'b0;
        vectors++; if (bus.host_rvalid !== 1'b1) begin miscompares++; $display("FAIL idle host_rvalid: got %b want 1", bus.host_rvalid); end
        vectors++; if (bus.host_rdata !== c_W10) begin miscompares++; $display("FAIL idle host_rdata: got %h want %h", bus.host_rdata, c_W10); end
        tick();
        vectors++; if (bus.host_rvalid !== 1'b0) begin miscompares++; $display("FAIL idle rvalid_pulse: got %b want 0", bus.host_rvalid); end
    endtask

    task automatic test_starvation();
        logic exp_g;
        bus.cpu_ren   = 1'b1;
        bus.cpu_addr  = 64'h8;
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 64'h20;
        for (int i = 0; i < 5; i++) begin
            exp_g = (i == 4);
            #2;
            vectors++; if (bus.host_gnt !== exp_g) begin miscompares++; $display("FAIL starve host_gnt[%0d]: got %b want %b", i, bus.host_gnt, exp_g); end
            vectors++; if (bus.cpu_stall !== exp_g) begin miscompares++; $display("FAIL starve cpu_stall[%0d]: got %b want %b", i, bus.cpu_stall, exp_g); end
            if (i < 4) begin
                vectors++; if (dut.r_wait_cnt !== 4'(i)) begin miscompares++; $display("FAIL starve wait_cnt[%0d]: got %0d want %0d", i, dut.r_wait_cnt, i); end
            end
            tick();
            if (i < 4) begin
                vectors++; if (bus.cpu_rdata !== c_W08) begin miscompares++; $display("FAIL starve cpu_rdata[%0d]: got %h want %h", i, bus.cpu_rdata, c_W08); end
            end
        end
        bus.host_req = 1'b0;
        vectors++; if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, c_W20}) begin miscompares++; $display("FAIL starve host_ret: got v=%b d=%h want v=1 d=%h", bus.host_rvalid, bus.host_rdata, c_W20); end
        vectors++; if (bus.cpu_rdata !== 64'h0) begin miscompares++; $display("FAIL starve cpu_rdata_host_cycle: got %h want 0", bus.cpu_rdata); end
        vectors++; if (bus.conflict_cnt !== 16'd1) begin miscompares++; $display("FAIL starve conflict_cnt: got %0d want 1", bus.conflict_cnt); end
        vectors++; if (dut.r_wait_cnt !== 4'd0) begin miscompares++; $display("FAIL starve wait_cnt_clear: got %0d want 0", dut.r_wait_cnt); end
        #2;
        vectors++; if ({bus.cpu_stall, bus.mem_ren, bus.mem_addr} !== {2'b01, 64'h8}) begin miscompares++; $display("FAIL starve release: got stall=%b ren=%b addr=%h want stall=0 ren=1 addr=8", bus.cpu_stall, bus.mem_ren, bus.mem_addr); end
        tick();
        bus.cpu_ren = 1'b0;
        vectors++; if (bus.cpu_rdata !== c_W08) begin miscompares++; $display("FAIL starve cpu_rdata_after: got %h want %h", bus.cpu_rdata, c_W08); end
    endtask

    task automatic test_alternating();
        for (int k = 0; k < 4; k++) begin
            bus.cpu_ren   = (k % 2 == 0);
            bus.cpu_addr  = 64'h8;
            bus.host_req  = (k % 2 == 1);
            bus.host_we   = 1'b0;
            bus.host_addr = 64'h20;
            #2;
            vectors++; if (bus.host_gnt !== (k % 2 == 1)) begin miscompares++; $display("FAIL alt host_gnt[%0d]: got %b want %b", k, bus.host_gnt, (k % 2 == 1)); end
            tick();
            if (k % 2 == 0) begin
                vectors++; if ({bus.host_rvalid, bus.cpu_rdata} !== {1'b0, c_W08}) begin miscompares++; $display("FAIL alt cpu_ret[%0d]: got v=%b d=%h want v=0 d=%h", k, bus.host_rvalid, bus.cpu_rdata, c_W08); end
            end else begin
                vectors++; if ({bus.host_rvalid, bus.host_rdata, bus.cpu_rdata} !== {1'b1, c_W20, 64'h0}) begin miscompares++; $display("FAIL alt host_ret[%0d]: got v=%b d=%h c=%h want v=1 d=%h c=0", k, bus.host_rvalid, bus.host_rdata, bus.cpu_rdata, c_W20); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_write_conflict();
        bus.cpu_wen    = 1'b1;
        bus.cpu_addr   = 64'h40;
        bus.cpu_wdata  = 64'h2;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 64'h40;
        bus.host_wdata = 64'h1;
        for (int i = 0; i < 5; i++) begin
            #2;
            vectors++; if (bus.host_gnt !== (i == 4)) begin miscompares++; $display("FAIL wconf host_gnt[%0d]: got %b want %b", i, bus.host_gnt, (i == 4)); end
            if (i == 4) begin
                vectors++; if ({bus.cpu_stall, bus.mem_wen, bus.mem_wdata} !== {2'b11, 64'h1}) begin miscompares++; $display("FAIL wconf forced: got stall=%b wen=%b wd=%h want stall=1 wen=1 wd=1", bus.cpu_stall, bus.mem_wen, bus.mem_wdata); end
            end
            tick();
        end
        bus.host_req = 1'b0;
        bus.cpu_ren  = 1'b1;
        #2;
        vectors++; if ({bus.cpu_stall, bus.mem_wen, bus.mem_ren, bus.mem_wdata} !== {3'b010, 64'h2}) begin miscompares++; $display("FAIL wconf cpu_after: got stall=%b wen=%b ren=%b wd=%h want stall=0 wen=1 ren=0 wd=2", bus.cpu_stall, bus.mem_wen, bus.mem_ren, bus.mem_wdata); end
        tick();
        idle_inputs();
        vectors++; if (sram[8] !== 64'h2) begin miscompares++; $display("FAIL wconf final_mem: got %h want 2", sram[8]); end
        vectors++; if (bus.conflict_cnt !== 16'd2) begin miscompares++; $display("FAIL wconf conflict_cnt: got %0d want 2", bus.conflict_cnt); end
        vectors++; if ({bus.host_rvalid, bus.cpu_rdata} !== {1'b0, 64'h0}) begin miscompares++; $display("FAIL wconf no_read: got v=%b c=%h want v=0 c=0", bus.host_rvalid, bus.cpu_rdata); end
    endtask

    task automatic test_cpu_disabled();
        bus.cpu_ren  = 1'b1;
        bus.cpu_addr = 64'h8;
        tick();
        bus.cpu_en     = 1'b0;
        bus.cpu_ren    = 1'b0;
        bus.cpu_wen    = 1'b1;
        bus.cpu_addr   = 64'h40;
        bus.cpu_wdata  = 64'h99;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b0;
        bus.host_addr  = 64'h40;
        #2;
        vectors++; if (bus.cpu_rdata !== c_W08) begin miscompares++; $display("FAIL dis outstanding_cpu_rdata: got %h want %h", bus.cpu_rdata, c_W08); end
        vectors++; if ({bus.host_gnt, bus.cpu_stall, bus.mem_wen, bus.mem_ren} !== 4'b1001) begin miscompares++; $display("FAIL dis host_read: got gnt=%b stall=%b wen=%b ren=%b want 1 0 0 1", bus.host_gnt, bus.cpu_stall, bus.mem_wen, bus.mem_ren); end
        tick();
        vectors++; if ({bus.host_rvalid, bus.host_rdata} !== {1'b1, 64'h2}) begin miscompares++; $display("FAIL dis host_ret: got v=%b d=%h want v=1 d=2", bus.host_rvalid, bus.host_rdata); end
        bus.host_we    = 1'b1;
        bus.host_addr  = 64'h48;
        bus.host_wdata = 64'h55;
        #2;
        vectors++; if ({bus.cpu_stall, bus.mem_wen, bus.mem_addr, bus.mem_wdata} !== {2'b01, 64'h48, 64'h55}) begin miscompares++; $display("FAIL dis host_write: got stall=%b wen=%b addr=%h wd=%h want 0 1 48 55", bus.cpu_stall, bus.mem_wen, bus.mem_addr, bus.mem_wdata); end
        tick();
        bus.host_req = 1'b0;
        #2;
        vectors++; if ({bus.host_gnt, bus.mem_wen, bus.mem_ren, bus.mem_addr} !== {3'b000, 64'h0}) begin miscompares++; $display("FAIL dis no_master: got gnt=%b wen=%b ren=%b addr=%h want 0 0 0 0", bus.host_gnt, bus.mem_wen, bus.mem_ren, bus.mem_addr); end
        tick();
        vectors++; if ({sram[8], sram[9]} !== {64'h2, 64'h55}) begin miscompares++; $display("FAIL dis mem_state: got %h %h want 2 55", sram[8], sram[9]); end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 64'h10;
        #2;
        vectors++; if (bus.host_gnt !== 1'b1) begin miscompares++; $display("FAIL rmid host_gnt: got %b want 1", bus.host_gnt); end
        #1;
        arst_n       = 1'b0;
        bus.host_req = 1'b0;
        #1;
        vectors++; if ({bus.host_gnt, bus.cpu_stall, bus.mem_wen, bus.mem_ren, bus.host_rvalid} !== 5'b0) begin miscompares++; $display("FAIL rmid in_reset: got gnt=%b stall=%b wen=%b ren=%b v=%b want all 0", bus.host_gnt, bus.cpu_stall, bus.mem_wen, bus.mem_ren, bus.host_rvalid); end
        vectors++; if (bus.conflict_cnt !== 16'd0) begin miscompares++; $display("FAIL rmid conflict_cnt: got %0d want 0", bus.conflict_cnt); end
        #1;
        arst_n = 1'b1;
        tick();
        vectors++; if ({bus.host_rvalid, bus.host_rdata, bus.cpu_rdata} !== {1'b0, 64'h0, 64'h0}) begin miscompares++; $display("FAIL rmid after_release: got v=%b d=%h c=%h want 0 0 0", bus.host_rvalid, bus.host_rdata, bus.cpu_rdata); end
        tick();
        vectors++; if (bus.host_rvalid !== 1'b0) begin miscompares++; $display("FAIL rmid late_rvalid: got %b want 0", bus.host_rvalid); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_host_read_idle();
        test_starvation();
        test_alternating();
        test_write_conflict();
        test_cpu_disabled();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
